// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I opcode constants, NOP encoding and immediate formats
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: fmt = IMM_I;
      OP_STORE:                 fmt = IMM_S;
      OP_BRANCH:                fmt = IMM_B;
      OP_LUI, OP_AUIPC:         fmt = IMM_U;
      OP_JAL:                   fmt = IMM_J;
      default:                  fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 integer register file, x0 hardwired to zero
// Write-through read bypass enabled by REGFILE_BYPASS_EN.
module regfile (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wren,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);

  logic [31:0] regs [32];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (i_wren && (i_wr_addr != 5'd0)) begin
      regs[i_wr_addr] <= i_wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Same-cycle write-back is visible on the read ports.
  assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'd0 :
                      (i_wren && (i_wr_addr == i_rs1_addr)) ? i_wr_data : regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'd0 :
                      (i_wren && (i_wr_addr == i_rs2_addr)) ? i_wr_data : regs[i_rs2_addr];
`else
  assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'd0 : regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'd0 : regs[i_rs2_addr];
`endif

endmodule

// File: rtl/stageid.sv
// rtl/stageid.sv - RV32I decode stage: IF/ID register, regfile, immgen, RAW stall
// REGFILE_BYPASS_EN drops the write-back term from the hazard check.
module stageid
  import rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_four,
  input  logic        i_flush,
  input  logic        i_wb_wren,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic [4:0]  i_ex_rd,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_ex_wren,
  input  logic        i_mem_wren,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm,
  output logic        o_valid,
  output logic        o_stall
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_four_q;
  logic        valid_q;

  logic [6:0]  opcode;
  logic        rs1_used;
  logic        rs2_used;
  logic        rs1_hit;
  logic        rs2_hit;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      instr_q   <= NOP;
      pc_q      <= '0;
      pc_four_q <= '0;
      valid_q   <= 1'b0;
    end else if (i_flush) begin
      instr_q   <= NOP;
      pc_q      <= '0;
      pc_four_q <= '0;
      valid_q   <= 1'b0;
    end else if (!o_stall) begin
      instr_q   <= i_instr;
      pc_q      <= i_pc;
      pc_four_q <= i_pc_four;
      valid_q   <= 1'b1;
    end
  end

  assign o_instr    = instr_q;
  assign o_pc       = pc_q;
  assign o_pc_four  = pc_four_q;
  assign opcode     = instr_q[6:0];
  assign o_rs1_addr = instr_q[19:15];
  assign o_rs2_addr = instr_q[24:20];
  assign o_rd_addr  = instr_q[11:7];

  regfile u_regfile (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wren     (i_wb_wren),
    .i_wr_addr  (i_wb_rd),
    .i_wr_data  (i_wb_data),
    .i_rs1_addr (o_rs1_addr),
    .i_rs2_addr (o_rs2_addr),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data)
  );

  always_comb begin
    o_imm = '0;
    case (imm_fmt(opcode))
      IMM_I:   o_imm = {{20{instr_q[31]}}, instr_q[31:20]};
      IMM_S:   o_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B:   o_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                        instr_q[30:25], instr_q[11:8], 1'b0};
      IMM_U:   o_imm = {instr_q[31:12], 12'd0};
      IMM_J:   o_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                        instr_q[20], instr_q[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

  assign rs1_used = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
  assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // Without forwarding, any in-flight writer of a used source must drain first.
  function automatic logic src_hit(input logic [4:0] rs);
    logic hit;
    hit = (i_ex_wren && (rs == i_ex_rd)) || (i_mem_wren && (rs == i_mem_rd));
`ifndef REGFILE_BYPASS_EN
    hit = hit || (i_wb_wren && (rs == i_wb_rd));
`endif
    return (rs != 5'd0) && hit;
  endfunction

  assign rs1_hit = rs1_used && src_hit(o_rs1_addr);
  assign rs2_hit = rs2_used && src_hit(o_rs2_addr);

  assign o_stall = valid_q && !i_flush && (rs1_hit || rs2_hit);
  assign o_valid = valid_q && !o_stall;

endmodule

// File: tb/tb_stageid.sv
// tb/tb_stageid.sv - directed self-checking bench for stageid
module tb_stageid;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic [31:0] i_pc_four;
  logic        i_flush;
  logic        i_wb_wren;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic [4:0]  i_ex_rd;
  logic [4:0]  i_mem_rd;
  logic        i_ex_wren;
  logic        i_mem_wren;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic [31:0] o_imm;
  logic        o_valid;
  logic        o_stall;

  int checks;
  int failures;

  stageid dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_pc_four  (i_pc_four),
    .i_flush    (i_flush),
    .i_wb_wren  (i_wb_wren),
    .i_wb_rd    (i_wb_rd),
    .i_wb_data  (i_wb_data),
    .i_ex_rd    (i_ex_rd),
    .i_mem_rd   (i_mem_rd),
    .i_ex_wren  (i_ex_wren),
    .i_mem_wren (i_mem_wren),
    .o_instr    (o_instr),
    .o_pc       (o_pc),
    .o_pc_four  (o_pc_four),
    .o_rs1_addr (o_rs1_addr),
    .o_rs2_addr (o_rs2_addr),
    .o_rd_addr  (o_rd_addr),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data),
    .o_imm      (o_imm),
    .o_valid    (o_valid),
    .o_stall    (o_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_reset = 1'b1;
    i_instr = 32'h0052_8333;
    i_pc = 32'h0;
    i_pc_four = 32'h4;
    i_flush = 1'b0;
    i_wb_wren = 1'b0;
    i_wb_rd = 5'd0;
    i_wb_data = 32'h0;
    i_ex_rd = 5'd0;
    i_mem_rd = 5'd0;
    i_ex_wren = 1'b0;
    i_mem_wren = 1'b0;
    tick();
    tick();

    chk("rst_instr", o_instr, 32'h13);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_rs1", o_rs1_data, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_imm", o_imm, 32'd0);

    // Write x5 while a NOP enters ID.
    i_reset = 1'b0;
    i_instr = 32'h0000_0013;
    i_wb_wren = 1'b1;
    i_wb_rd = 5'd5;
    i_wb_data = 32'hDEAD_BEEF;
    tick();
    i_wb_wren = 1'b0;
    i_instr = 32'h0052_8333;
    i_pc = 32'h100;
    i_pc_four = 32'h104;
    tick();
    chk("add_instr", o_instr, 32'h0052_8333);
    chk("add_rs1", o_rs1_data, 32'hDEAD_BEEF);
    chk("add_rs2", o_rs2_data, 32'hDEAD_BEEF);
    chk("add_rd", {27'd0, o_rd_addr}, 32'd6);
    chk("add_rs1a", {27'd0, o_rs1_addr}, 32'd5);
    chk("add_valid", {31'd0, o_valid}, 32'd1);
    chk("add_pc", o_pc, 32'h100);
    chk("add_pc4", o_pc_four, 32'h104);
    chk("add_imm", o_imm, 32'd0);

    // EX hazard on x5 freezes IF/ID.
    i_instr = 32'h0000_0013;
    i_pc = 32'h104;
    i_pc_four = 32'h108;
    i_ex_rd = 5'd5;
    i_ex_wren = 1'b1;
    #1;
    chk("ex_stall", {31'd0, o_stall}, 32'd1);
    chk("ex_valid", {31'd0, o_valid}, 32'd0);
    tick();
    chk("ex_hold_instr", o_instr, 32'h0052_8333);
    chk("ex_hold_pc", o_pc, 32'h100);
    chk("ex_hold_stall", {31'd0, o_stall}, 32'd1);
    i_ex_wren = 1'b0;
    #1;
    chk("ex_rel_stall", {31'd0, o_stall}, 32'd0);
    chk("ex_rel_valid", {31'd0, o_valid}, 32'd1);

    // MEM hazard.
    i_mem_rd = 5'd5;
    i_mem_wren = 1'b1;
    #1;
    chk("mem_stall", {31'd0, o_stall}, 32'd1);
    i_mem_wren = 1'b0;

    // WB hazard only without bypass; with bypass the new value is seen.
    i_wb_wren = 1'b1;
    i_wb_rd = 5'd5;
    i_wb_data = 32'h1111_1111;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wb_stall", {31'd0, o_stall}, 32'd0);
    chk("wb_rs1", o_rs1_data, 32'h1111_1111);
`else
    chk("wb_stall", {31'd0, o_stall}, 32'd1);
    chk("wb_rs1", o_rs1_data, 32'hDEAD_BEEF);
`endif
    i_wb_wren = 1'b0;

    // Flush while stalled.
    i_ex_wren = 1'b1;
    #1;
    chk("fl_pre_stall", {31'd0, o_stall}, 32'd1);
    i_flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, o_stall}, 32'd0);
    tick();
    i_flush = 1'b0;
    #1;
    chk("fl_instr", o_instr, 32'h13);
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_pc", o_pc, 32'd0);
    chk("fl_stall2", {31'd0, o_stall}, 32'd0);
    i_ex_wren = 1'b0;

    // x0 write ignored; addi x1,x0,-1.
    i_wb_wren = 1'b1;
    i_wb_rd = 5'd0;
    i_wb_data = 32'h1234;
    i_instr = 32'h0000_0013;
    tick();
    i_wb_wren = 1'b0;
    i_instr = 32'hFFF0_0093;
    tick();
    chk("x0_rs1", o_rs1_data, 32'd0);
    chk("addi_imm", o_imm, 32'hFFFF_FFFF);
    i_ex_rd = 5'd0;
    i_ex_wren = 1'b1;
    #1;
    chk("x0_nostall", {31'd0, o_stall}, 32'd0);
    chk("x0_valid", {31'd0, o_valid}, 32'd1);
    i_ex_wren = 1'b0;

    // beq x0,x0,-4
    i_instr = 32'hFE00_0EE3;
    tick();
    chk("beq_imm", o_imm, 32'hFFFF_FFFC);

    // sw x5,-4(x2): rs2 dependency stalls.
    i_instr = 32'hFE51_2E23;
    tick();
    chk("sw_imm", o_imm, 32'hFFFF_FFFC);
    i_ex_rd = 5'd5;
    i_ex_wren = 1'b1;
    #1;
    chk("sw_rs2_stall", {31'd0, o_stall}, 32'd1);
    i_ex_wren = 1'b0;

    // lui x1,0x12345: rs1 field (8) is unused.
    i_instr = 32'h1234_50B7;
    tick();
    chk("lui_imm", o_imm, 32'h1234_5000);
    i_ex_rd = 5'd8;
    i_ex_wren = 1'b1;
    #1;
    chk("lui_nostall", {31'd0, o_stall}, 32'd0);
    i_ex_wren = 1'b0;

    // jal x1,8
    i_instr = 32'h0080_00EF;
    tick();
    chk("jal_imm", o_imm, 32'h0000_0008);
    chk("jal_rd", {27'd0, o_rd_addr}, 32'd1);

    // Reset mid-stall.
    i_instr = 32'h0052_8333;
    tick();
    i_ex_rd = 5'd5;
    i_ex_wren = 1'b1;
    #1;
    chk("rs_pre_stall", {31'd0, o_stall}, 32'd1);
    i_reset = 1'b1;
    #1;
    chk("rs_stall", {31'd0, o_stall}, 32'd0);
    chk("rs_instr", o_instr, 32'h13);
    chk("rs_valid", {31'd0, o_valid}, 32'd0);
    i_ex_wren = 1'b0;
    tick();
    i_reset = 1'b0;
    tick();
    chk("rs_reload", o_instr, 32'h0052_8333);
    chk("rs_rf_clear", o_rs1_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
